// File: rtl/vec3_normalize_iter.sv
`default_nettype none
// ============================================================================
// Module   : vec3_normalize_iter
// Purpose  : Iterative normalisation of a signed 3-component vector.
//            Computes S = x^2+y^2+z^2, M = floor(sqrt(S)) with a bit-serial
//            restoring square root, then divides each component by M with a
//            single shared restoring divider. The result is Q.FRAC, clipped
//            to +/-2^FRAC. Latency is fixed at 4*WIDTH+3*FRAC+2 cycles.
// Ports    : clk, rst_n (synchronous, active-low)
//            in_valid / in_ready / in_x, in_y, in_z   : input vector handshake
//            out_valid / out_ready / out_x, out_y, out_z, out_zero : result
// Config   : define VEC3_NORM_ROUND_EN to round the quotient to nearest
//            (adds floor(M/2) to the dividend); otherwise it truncates.
// Revision : 1.0  initial release
// ============================================================================
module vec3_normalize_iter #(
  parameter int WIDTH = 12,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero
);

  localparam int SW = 2*WIDTH+2;          // sum of squares width
  localparam int MW = WIDTH+1;            // magnitude / root width
  localparam int DW = WIDTH+FRAC;         // dividend and quotient width
  localparam int RW = WIDTH+3;            // square-root partial remainder
  localparam int CW = $clog2(DW+1);       // step counter width

  localparam logic [DW-1:0] Q_MAX = DW'(1) << FRAC;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAG  = 3'd1;
  localparam logic [2:0] S_SQRT = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;

  logic [WIDTH-1:0] x_reg, y_reg, z_reg;
  logic [CW-1:0]    cnt;
  logic [1:0]       div_comp;
  logic [SW-1:0]    sqrt_src;
  logic [RW-1:0]    sqrt_rem;
  logic [MW-1:0]    sqrt_root;
  logic [MW-1:0]    div_rem;
  logic [DW-2:0]    div_quo;
  logic [DW-1:0]    div_dvd;
  logic [WIDTH-1:0] res_x, res_y;

  // Magnitude in WIDTH+1 bits so that -2^(WIDTH-1) is representable.
  function automatic logic [MW-1:0] magnitude(input logic [WIDTH-1:0] c);
    logic [MW-1:0] ext;
    ext = {c[WIDTH-1], c};
    return c[WIDTH-1] ? (~ext + MW'(1)) : ext;
  endfunction

  logic [MW-1:0] mag_x, mag_y, mag_z;
  logic [SW-1:0] sq_x, sq_y, sq_z, sum_sq;

  assign mag_x  = magnitude(x_reg);
  assign mag_y  = magnitude(y_reg);
  assign mag_z  = magnitude(z_reg);
  assign sq_x   = SW'(mag_x) * SW'(mag_x);
  assign sq_y   = SW'(mag_y) * SW'(mag_y);
  assign sq_z   = SW'(mag_z) * SW'(mag_z);
  assign sum_sq = sq_x + sq_y + sq_z;

  // Restoring square root step: bring down two radicand bits, try
  // subtracting (4*root + 1).
  logic [RW+1:0] srem_sh;
  logic [RW+1:0] strial;
  logic          sqrt_ge;
  logic [RW-1:0] sqrt_rem_nx;
  logic [MW-1:0] sqrt_root_nx;

  assign srem_sh      = {sqrt_rem, sqrt_src[SW-1 -: 2]};
  assign strial       = (RW+2)'({sqrt_root, 2'b01});
  assign sqrt_ge      = (srem_sh >= strial);
  assign sqrt_rem_nx  = sqrt_ge ? RW'(srem_sh - strial) : RW'(srem_sh);
  assign sqrt_root_nx = {sqrt_root[MW-2:0], sqrt_ge};

  // Restoring division step against M (held in sqrt_root during DIV).
  logic [MW:0]      drem_sh;
  logic             div_ge;
  logic [MW-1:0]    drem_nx;
  logic [DW-1:0]    quo_nx;
  logic [DW-1:0]    quo_clip;
  logic [WIDTH-1:0] quo_w;
  logic             comp_neg;
  logic [WIDTH-1:0] div_result;

  assign drem_sh  = {div_rem, div_dvd[DW-1]};
  assign div_ge   = (drem_sh >= {1'b0, sqrt_root});
  assign drem_nx  = div_ge ? MW'(drem_sh - {1'b0, sqrt_root}) : MW'(drem_sh);
  assign quo_nx   = {div_quo, div_ge};
  assign quo_clip = (quo_nx > Q_MAX) ? Q_MAX : quo_nx;
  assign quo_w    = WIDTH'(quo_clip);

  always_comb begin
    comp_neg = 1'b0;
    case (div_comp)
      2'd0:    comp_neg = x_reg[WIDTH-1];
      2'd1:    comp_neg = y_reg[WIDTH-1];
      default: comp_neg = z_reg[WIDTH-1];
    endcase
  end

  // M = 0 only when S = 0; the raw divider would produce all-ones there,
  // so the result is forced to zero instead.
  assign div_result = (sqrt_root == '0) ? '0 :
                      (comp_neg ? (-quo_w) : quo_w);

  // Dividend loads. The x load happens on the last SQRT cycle, before the
  // final root is registered, so it uses the root being written.
  logic [DW-1:0] load_x, load_y, load_z;
`ifdef VEC3_NORM_ROUND_EN
  logic [MW-1:0] load_m;
  assign load_m = (state == S_SQRT) ? sqrt_root_nx : sqrt_root;
  assign load_x = (DW'(mag_x) << FRAC) + DW'(load_m >> 1);
  assign load_y = (DW'(mag_y) << FRAC) + DW'(load_m >> 1);
  assign load_z = (DW'(mag_z) << FRAC) + DW'(load_m >> 1);
`else
  assign load_x = DW'(mag_x) << FRAC;
  assign load_y = DW'(mag_y) << FRAC;
  assign load_z = DW'(mag_z) << FRAC;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = S_MAG;
      S_MAG:  state_next = S_SQRT;
      S_SQRT: if (cnt == CW'(WIDTH)) state_next = S_DIV;
      S_DIV:  if ((cnt == CW'(DW-1)) && (div_comp == 2'd2)) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
      out_zero <= 1'b0;
      cnt      <= '0;
      div_comp <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_reg <= in_x;
            y_reg <= in_y;
            z_reg <= in_z;
          end
        end
        S_MAG: begin
          sqrt_src  <= sum_sq;
          sqrt_rem  <= '0;
          sqrt_root <= '0;
          cnt       <= '0;
        end
        S_SQRT: begin
          sqrt_src  <= sqrt_src << 2;
          sqrt_rem  <= sqrt_rem_nx;
          sqrt_root <= sqrt_root_nx;
          if (cnt == CW'(WIDTH)) begin
            cnt      <= '0;
            div_comp <= 2'd0;
            div_rem  <= '0;
            div_quo  <= '0;
            div_dvd  <= load_x;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          div_rem <= drem_nx;
          div_quo <= quo_nx[DW-2:0];
          div_dvd <= div_dvd << 1;
          if (cnt == CW'(DW-1)) begin
            cnt     <= '0;
            div_rem <= '0;
            div_quo <= '0;
            case (div_comp)
              2'd0: begin
                res_x    <= div_result;
                div_dvd  <= load_y;
                div_comp <= 2'd1;
              end
              2'd1: begin
                res_y    <= div_result;
                div_dvd  <= load_z;
                div_comp <= 2'd2;
              end
              default: begin
                // Results become visible only on entry to DONE.
                out_x    <= res_x;
                out_y    <= res_y;
                out_z    <= div_result;
                out_zero <= (sqrt_root == '0);
              end
            endcase
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec3_normalize_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vec3_normalize_iter
// Purpose  : Self-checking bench for vec3_normalize_iter (WIDTH=12, FRAC=4).
//            Reference values come from integer arithmetic on the accepted
//            vector; a per-cycle compare process tracks each transaction.
// Revision : 1.0  initial release
// ============================================================================
module tb_vec3_normalize_iter;

  localparam int WIDTH = 12;
  localparam int FRAC  = 4;
  localparam int L     = 4*WIDTH + 3*FRAC + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic [WIDTH-1:0] in_z = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_x, out_y, out_z;
  logic             out_zero;

  vec3_normalize_iter #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sx(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  // ---------------- reference model ----------------
  function automatic longint isqrt(input longint s);
    longint lo, hi, mid;
    lo = 0;
    hi = 1 << (WIDTH + 1);
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic int norm_comp(input int c, input longint m);
    longint a, q;
    if (m == 0) return 0;
    a = (c < 0) ? -c : c;
    q = a * (1 << FRAC);
`ifdef VEC3_NORM_ROUND_EN
    q = q + m / 2;
`endif
    q = q / m;
    if (q > (1 << FRAC)) q = 1 << FRAC;
    return (c < 0) ? -int'(q) : int'(q);
  endfunction

  // ---------------- per-cycle compare process ----------------
  bit armed    = 1'b0;
  bit have_txn = 1'b0;
  int acc      = 0;
  int ex = 0, ey = 0, ez = 0, ezr = 0;
  int lx = 0, ly = 0, lz = 0, lzr = 0;

  always @(negedge clk) begin : compare
    int  n;
    int  a, b, c;
    longint s, m;
    n = cyc - acc;
    if (armed) begin
      if (have_txn && n >= L) begin
        chk("done.out_valid", out_valid, 1);
        chk("done.in_ready", in_ready, 0);
        chk("done.out_x", sx(out_x), ex);
        chk("done.out_y", sx(out_y), ey);
        chk("done.out_z", sx(out_z), ez);
        chk("done.out_zero", out_zero, ezr);
      end else begin
        chk("out_valid", out_valid, 0);
        chk("in_ready", in_ready, have_txn ? 0 : 1);
        chk("hold.out_x", sx(out_x), lx);
        chk("hold.out_y", sx(out_y), ly);
        chk("hold.out_z", sx(out_z), lz);
        chk("hold.out_zero", out_zero, lzr);
      end
    end
    // Predict the effect of the coming rising edge.
    if (!rst_n) begin
      armed    = 1'b1;
      have_txn = 1'b0;
      lx = 0; ly = 0; lz = 0; lzr = 0;
    end else if (armed) begin
      if (have_txn) begin
        if (n >= L && out_ready) begin
          have_txn = 1'b0;
          lx = ex; ly = ey; lz = ez; lzr = ezr;
        end
      end else if (in_valid) begin
        a = sx(in_x); b = sx(in_y); c = sx(in_z);
        s = longint'(a) * a + longint'(b) * b + longint'(c) * c;
        m = isqrt(s);
        ex  = norm_comp(a, m);
        ey  = norm_comp(b, m);
        ez  = norm_comp(c, m);
        ezr = (s == 0) ? 1 : 0;
        acc = cyc + 1;
        have_txn = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int x, input int y, input int z);
    int k;
    in_x = WIDTH'(x);
    in_y = WIDTH'(y);
    in_z = WIDTH'(z);
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("send.in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < L + 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, k, L);
  endtask

  task automatic run_vec(input string tag, input int x, input int y, input int z,
                         input int vx, input int vy, input int vz, input int vzr);
    send(x, y, z);
    wait_valid(tag);
    chk({tag, ".x"}, sx(out_x), vx);
    chk({tag, ".y"}, sx(out_y), vy);
    chk({tag, ".z"}, sx(out_z), vz);
    chk({tag, ".zero"}, out_zero, vzr);
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_comp();
    case ($urandom % 8)
      0:       return -2048;
      1:       return 2047;
      2:       return 0;
      3:       return int'($urandom_range(0, 6)) - 3;
      default: return int'($urandom % 4096) - 2048;
    endcase
  endfunction

  int rx, ry;

  initial begin
`ifdef VEC3_NORM_ROUND_EN
    rx = 10; ry = 13;
`else
    rx = 9;  ry = 12;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_x", sx(out_x), 0);
    chk("reset.out_zero", out_zero, 0);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    run_vec("v48_64", 48, 64, 0, rx, ry, 0, 0);
    run_vec("vzero", 0, 0, 0, 0, 0, 0, 1);
    run_vec("vneg", -2048, 0, 0, -16, 0, 0, 0);
    run_vec("v111", 1, 1, 1, 16, 16, 16, 0);

    // Back-pressure: result held while out_ready is low; inputs ignored.
    out_ready = 1'b0;
    send(48, 64, 0);
    wait_valid("bp");
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      in_x = WIDTH'(i + 5);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.x", sx(out_x), rx);
    chk("bp.y", sx(out_y), ry);
    chk("bp.in_ready", in_ready, 0);
    chk("bp.out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.release.in_ready", in_ready, 1);
    chk("bp.release.out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Reset during DIV abandons the transaction.
    send(100, -7, 33);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_x", sx(out_x), 0);
    @(posedge clk);
    #1;
    run_vec("after_rst", 48, 64, 0, rx, ry, 0, 0);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_x      = WIDTH'(rand_comp());
      in_y      = WIDTH'(rand_comp());
      in_z      = WIDTH'(rand_comp());
      out_ready = ($urandom % 3) != 0;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (L + 10) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
